// File: rtl/chess_clock_ctrl_pkg.sv
// Shared encodings for the two-player chess clock: FSM states, BCD timer word, side-to-move.
// latency: n/a (types only); backpressure: n/a.
package chess_clock_ctrl_pkg;

    localparam int TIMER_W = 16;

    typedef logic [TIMER_W-1:0] timer_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_RED = 1'b0,
        SIDE_BLK = 1'b1
    } side_t;

    function automatic side_t other_side(side_t s);
        return (s == SIDE_RED) ? SIDE_BLK : SIDE_RED;
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// One-second decrement of a packed BCD mm:ss word, saturating at 00:00; zero flags a 00:00 result.
// latency: combinational; backpressure: none.
module bcd_mmss_dec
    import chess_clock_ctrl_pkg::*;
(
    input  timer_t val,
    output timer_t dec,
    output logic   zero
);

    logic [3:0] sec_d;
    logic [3:0] tsec_d;
    logic [3:0] min_d;
    logic [3:0] tmin_d;
    logic       borrow;

    always_comb begin
        sec_d  = val[3:0];
        tsec_d = val[7:4];
        min_d  = val[11:8];
        tmin_d = val[15:12];
        borrow = 1'b0;
        if (val != '0) begin
            if (sec_d != 4'd0) begin
                sec_d = sec_d - 4'd1;
            end else begin
                sec_d  = 4'd9;
                borrow = 1'b1;
            end
            if (borrow) begin
                if (tsec_d != 4'd0) begin
                    tsec_d = tsec_d - 4'd1;
                    borrow = 1'b0;
                end else begin
                    tsec_d = 4'd5;
                end
            end
            if (borrow) begin
                if (min_d != 4'd0) begin
                    min_d  = min_d - 4'd1;
                    borrow = 1'b0;
                end else begin
                    min_d = 4'd9;
                end
            end
            // A non-zero word always has a non-zero digit left to absorb the borrow.
            if (borrow) begin
                tmin_d = tmin_d - 4'd1;
            end
        end
        dec  = {tmin_d, min_d, tsec_d, sec_d};
        zero = (dec == '0);
    end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock sequencer: counts down the side to move once per second, swaps turn on move, flags timeout.
// latency: all outputs registered, one edge from the sampled pulse; backpressure: none, pulses outside their state are dropped.
module chess_clock_ctrl
    import chess_clock_ctrl_pkg::*;
#(
    parameter int          CLK_HZ     = 25_000_000,
    parameter logic [15:0] ROUND_INIT = 16'h0100,
    parameter logic [15:0] TOTAL_INIT = 16'h1000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        move_done,
    output logic [15:0] rr_timer,
    output logic [15:0] rt_timer,
    output logic [15:0] br_timer,
    output logic [15:0] bt_timer,
    output logic        turn,
    output logic        running,
    output logic        timeout,
    output logic        loser
);

    localparam int            PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    side_t         turn_q;
    logic          loser_q;

    timer_t act_round;
    timer_t act_total;
    timer_t round_dec;
    timer_t total_dec;
    logic   round_zero;
    logic   total_zero;
    logic   tick;

    assign act_round = (turn_q == SIDE_RED) ? rr_timer : br_timer;
    assign act_total = (turn_q == SIDE_RED) ? rt_timer : bt_timer;
    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    bcd_mmss_dec u_round_dec (
        .val  (act_round),
        .dec  (round_dec),
        .zero (round_zero)
    );

    bcd_mmss_dec u_total_dec (
        .val  (act_total),
        .dec  (total_dec),
        .zero (total_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            turn_q   <= SIDE_RED;
            loser_q  <= 1'b0;
            rr_timer <= ROUND_INIT;
            br_timer <= ROUND_INIT;
            rt_timer <= TOTAL_INIT;
            bt_timer <= TOTAL_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        presc_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (move_done) begin
                        // A move landing on the tick cycle swallows that tick entirely.
                        presc_q <= '0;
                        if (turn_q == SIDE_RED) begin
                            rr_timer <= ROUND_INIT;
                        end else begin
                            br_timer <= ROUND_INIT;
                        end
                        turn_q <= other_side(turn_q);
                        if (pause) begin
                            state_q <= ST_PAUSE;
                        end
                    end else if (tick) begin
                        presc_q <= '0;
                        if (turn_q == SIDE_RED) begin
                            rr_timer <= round_dec;
                            rt_timer <= total_dec;
                        end else begin
                            br_timer <= round_dec;
                            bt_timer <= total_dec;
                        end
                        if (round_zero || total_zero) begin
                            state_q <= ST_OVER;
                            loser_q <= turn_q;
                        end else if (pause) begin
                            state_q <= ST_PAUSE;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                        if (pause) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    // Prescaler is left untouched so the interrupted second resumes where it stopped.
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign turn    = turn_q;
    assign running = (state_q == ST_RUN);
    assign timeout = (state_q == ST_OVER);
    assign loser   = loser_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Scoreboarded bench: two clock instances with different parameters, model in plain seconds.
module tb_chess_clock_ctrl;

    localparam int          HZ0 = 4;
    localparam logic [15:0] RI0 = 16'h0100;
    localparam logic [15:0] TI0 = 16'h1000;
    localparam int          HZ1 = 3;
    localparam logic [15:0] RI1 = 16'h1000;
    localparam logic [15:0] TI1 = 16'h0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, start_v, pause_v, move_v;
    logic [15:0] rr0, rt0, br0, bt0, rr1, rt1, br1, bt1;
    logic turn0, run0, to0, lo0, turn1, run1, to1, lo1;

    chess_clock_ctrl #(.CLK_HZ(HZ0), .ROUND_INIT(RI0), .TOTAL_INIT(TI0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .pause(pause_v[0]), .move_done(move_v[0]),
        .rr_timer(rr0), .rt_timer(rt0), .br_timer(br0), .bt_timer(bt0),
        .turn(turn0), .running(run0), .timeout(to0), .loser(lo0)
    );

    chess_clock_ctrl #(.CLK_HZ(HZ1), .ROUND_INIT(RI1), .TOTAL_INIT(TI1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .pause(pause_v[1]), .move_done(move_v[1]),
        .rr_timer(rr1), .rt_timer(rt1), .br_timer(br1), .bt_timer(bt1),
        .turn(turn1), .running(run1), .timeout(to1), .loser(lo1)
    );

    typedef struct packed {
        logic [15:0] rr;
        logic [15:0] rt;
        logic [15:0] br;
        logic [15:0] bt;
        logic        turn;
        logic        running;
        logic        timeout;
        logic        loser;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int hz[2];
    int ri[2];
    int ti[2];
    // Model state: 0 idle, 1 run, 2 pause, 3 over; timers held as plain seconds.
    int m_phase[2];
    int m_cnt[2];
    int m_rr[2], m_rt[2], m_br[2], m_bt[2];
    bit m_turn[2];
    bit m_loser[2];

    int n_chk = 0;
    int n_fail = 0;

    function automatic int bcd2s(logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] s2bcd(int s);
        int m;
        int x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int dec1(int s);
        return (s > 0) ? s - 1 : 0;
    endfunction

    task automatic model_step(int k, bit r, bit st, bit pa, bit mv);
        exp_t e;
        bit   hit;
        if (r) begin
            m_phase[k] = 0;
            m_cnt[k]   = 0;
            m_turn[k]  = 1'b0;
            m_loser[k] = 1'b0;
            m_rr[k]    = ri[k];
            m_br[k]    = ri[k];
            m_rt[k]    = ti[k];
            m_bt[k]    = ti[k];
        end else begin
            case (m_phase[k])
                0: if (st) begin
                    m_phase[k] = 1;
                    m_cnt[k]   = 0;
                end
                1: begin
                    if (mv) begin
                        m_cnt[k] = 0;
                        if (!m_turn[k]) m_rr[k] = ri[k];
                        else            m_br[k] = ri[k];
                        m_turn[k] = !m_turn[k];
                        if (pa) m_phase[k] = 2;
                    end else if (m_cnt[k] == hz[k] - 1) begin
                        m_cnt[k] = 0;
                        if (!m_turn[k]) begin
                            m_rr[k] = dec1(m_rr[k]);
                            m_rt[k] = dec1(m_rt[k]);
                            hit = (m_rr[k] == 0) || (m_rt[k] == 0);
                        end else begin
                            m_br[k] = dec1(m_br[k]);
                            m_bt[k] = dec1(m_bt[k]);
                            hit = (m_br[k] == 0) || (m_bt[k] == 0);
                        end
                        if (hit) begin
                            m_phase[k] = 3;
                            m_loser[k] = m_turn[k];
                        end else if (pa) begin
                            m_phase[k] = 2;
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                        if (pa) m_phase[k] = 2;
                    end
                end
                2: if (st) m_phase[k] = 1;
                default: ;
            endcase
        end
        e.rr      = s2bcd(m_rr[k]);
        e.rt      = s2bcd(m_rt[k]);
        e.br      = s2bcd(m_br[k]);
        e.bt      = s2bcd(m_bt[k]);
        e.turn    = m_turn[k];
        e.running = (m_phase[k] == 1);
        e.timeout = (m_phase[k] == 3);
        e.loser   = m_loser[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Drive one cycle of pulses (bit k goes to instance k), record expectations, advance past the edge.
    task automatic cyc(input logic [1:0] r, input logic [1:0] st, input logic [1:0] pa, input logic [1:0] mv);
        rst_v   = r;
        start_v = st;
        pause_v = pa;
        move_v  = mv;
        for (int k = 0; k < 2; k++) model_step(k, r[k], st[k], pa[k], mv[k]);
        @(posedge clk);
        #1;
        rst_v   = 2'b00;
        start_v = 2'b00;
        pause_v = 2'b00;
        move_v  = 2'b00;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("rr_timer", 0, rr0, e0.rr);
            chk("rt_timer", 0, rt0, e0.rt);
            chk("br_timer", 0, br0, e0.br);
            chk("bt_timer", 0, bt0, e0.bt);
            chk("turn",     0, {15'b0, turn0}, {15'b0, e0.turn});
            chk("running",  0, {15'b0, run0},  {15'b0, e0.running});
            chk("timeout",  0, {15'b0, to0},   {15'b0, e0.timeout});
            chk("loser",    0, {15'b0, lo0},   {15'b0, e0.loser});
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("rr_timer", 1, rr1, e1.rr);
            chk("rt_timer", 1, rt1, e1.rt);
            chk("br_timer", 1, br1, e1.br);
            chk("bt_timer", 1, bt1, e1.bt);
            chk("turn",     1, {15'b0, turn1}, {15'b0, e1.turn});
            chk("running",  1, {15'b0, run1},  {15'b0, e1.running});
            chk("timeout",  1, {15'b0, to1},   {15'b0, e1.timeout});
            chk("loser",    1, {15'b0, lo1},   {15'b0, e1.loser});
        end
    end

    initial begin
        logic [1:0] r, st, pa, mv;
        int i;
        hz[0] = HZ0; ri[0] = bcd2s(RI0); ti[0] = bcd2s(TI0);
        hz[1] = HZ1; ri[1] = bcd2s(RI1); ti[1] = bcd2s(TI1);
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_cnt[k] = 0; m_turn[k] = 1'b0; m_loser[k] = 1'b0;
            m_rr[k] = 0; m_rt[k] = 0; m_br[k] = 0; m_bt[k] = 0;
        end
        rst_v = 2'b00; start_v = 2'b00; pause_v = 2'b00; move_v = 2'b00;

        cyc(2'b11, 2'b00, 2'b00, 2'b00);
        cyc(2'b11, 2'b00, 2'b00, 2'b00);
        // Pause and move pulses must be ignored while idle.
        cyc(2'b00, 2'b00, 2'b11, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b11);
        idle(2);

        cyc(2'b00, 2'b11, 2'b00, 2'b00);
        idle(8);
        cyc(2'b00, 2'b00, 2'b00, 2'b11);
        idle(6);

        // Move exactly on instance 0's tick cycle.
        i = 0;
        while (i < 20 && !(m_phase[0] == 1 && m_cnt[0] == HZ0 - 1)) begin
            idle(1);
            i++;
        end
        cyc(2'b00, 2'b00, 2'b00, 2'b11);
        idle(6);

        // Pause mid-second, hold, then resume.
        idle(1);
        cyc(2'b00, 2'b00, 2'b11, 2'b00);
        idle(100);
        cyc(2'b00, 2'b11, 2'b00, 2'b00);
        idle(10);

        cyc(2'b00, 2'b00, 2'b11, 2'b11);
        idle(5);
        cyc(2'b00, 2'b11, 2'b00, 2'b00);

        // Let the active side run out, then poke the finished game.
        idle(300);
        cyc(2'b00, 2'b11, 2'b11, 2'b11);
        idle(10);
        cyc(2'b00, 2'b00, 2'b00, 2'b11);
        idle(3);
        cyc(2'b11, 2'b00, 2'b00, 2'b00);
        idle(3);

        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 2; k++) begin
                r[k]  = ($urandom_range(0, 299) == 0);
                st[k] = ($urandom_range(0, 15) == 0);
                pa[k] = ($urandom_range(0, 39) == 0);
                mv[k] = ($urandom_range(0, 9) == 0);
            end
            cyc(r, st, pa, mv);
        end
        idle(2);

        repeat (3) @(negedge clk);
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Sequencer for the two player clocks on the chess screen. Owns the red and black round (per-move) and total (per-game) countdown timers as packed BCD mm:ss words, advances only the side to move once per second, hands the turn over on each committed move, and flags a timeout. Its four timer outputs drive the player-timer pixel renderer directly; its `turn` output feeds the move-input logic.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: clock cycles per one-second tick; must be ≥ 2.
- `ROUND_INIT`, 16'h0100: round-timer load value, BCD mm:ss (01:00).
- `TOTAL_INIT`, 16'h1000: total-timer load value, BCD mm:ss (10:00).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or resumes the game.
- `pause`  in  1  one-cycle pulse; freezes the clocks.
- `move_done`  in  1  one-cycle pulse; the side to move has committed.
- `rr_timer`, `rt_timer`  out  16  red round / red total, BCD [15:12] tens of min, [11:8] min, [7:4] tens of sec, [3:0] sec.
- `br_timer`, `bt_timer`  out  16  black round / black total, same format.
- `turn`  out  1  side to move: 0 red, 1 black.
- `running`  out  1  high in RUN.
- `timeout`  out  1  high in OVER.
- `loser`  out  1  side that timed out; valid while `timeout` is high.

## Operation
- States: IDLE, RUN, PAUSE, OVER.
  - IDLE: `start` → RUN.
  - RUN: `pause` → PAUSE; timeout → OVER.
  - PAUSE: `start` → RUN.
  - OVER: leaves only on `rst`.
- Inputs with no defined transition in the current state are ignored, including `move_done` outside RUN.
- Prescaler: counts 0..CLK_HZ-1 only in RUN, and holds its value in PAUSE.
  - It emits `tick` on the cycle when it reaches CLK_HZ-1, then wraps to 0.
  - It clears to 0 on entry to RUN from IDLE and on every accepted `move_done`.
- On `tick` in RUN: decrement the active side's round and total timers by one second, BCD.
  - Seconds digit 0 → 9 with borrow; tens-of-seconds 0 → 5 with borrow; minutes 0 → 9 with borrow.
  - A timer at 0000 saturates at 0000.
- Timeout: if either decremented value of the active side equals 16'h0000, the next state is OVER, `loser` = `turn`, and the 0000 value is stored.
- On accepted `move_done`: the outgoing side's round timer reloads to ROUND_INIT, `turn` toggles, and total timers are untouched.
- Simultaneous `move_done` and `tick`: the move wins. The tick is discarded, no decrement happens and no timeout is checked.
- Simultaneous `pause` and `move_done` in RUN: both apply (turn switches, state goes to PAUSE).
- Simultaneous `pause` and `tick`: the decrement and any timeout apply first. If a timeout occurs, OVER takes priority over PAUSE.

## Timing
- Reset values:
  - State IDLE, prescaler 0, `turn` 0.
  - `rr_timer` = `br_timer` = ROUND_INIT; `rt_timer` = `bt_timer` = TOTAL_INIT.
  - `running` = `timeout` = `loser` = 0.
- `rst` mid-game returns to these values on the next edge, from any state.
- All outputs are registered. Flag outputs are decoded from the state register with no added latency.
- Latencies:
  - `start` sampled at edge N → `running` = 1 after edge N.
  - First decrement lands CLK_HZ edges after the `start` edge.
  - `move_done` at edge M → `turn` toggles and the round reload are visible after edge M.
  - The new side's first decrement lands CLK_HZ edges later.
- Timeout: the 0000 value and `timeout` = 1 become visible on the same edge.

## Structure
- Shared defines header holds:
  - state encodings;
  - BCD timer width `TIMER_W` = 16;
  - colour-independent side encoding (RED = 0, BLK = 1).
- Sub-module `bcd_mmss_dec`: a combinational one-second BCD mm:ss decrementer with saturation and a `zero` output.
  - Two instances: active round and active total.
  - Their inputs are muxed by `turn`.
- Expected size about 180 RTL lines.

## Test plan
- Reset then `start`, CLK_HZ = 4, 8 cycles:
  - `rr_timer` 0100 → 0059 → 0058 and `rt_timer` 1000 → 0959 → 0958.
  - Black timers stay unchanged.
- Pulse `move_done` after red is at 0058:
  - `rr_timer` = 0100 and `turn` = 1.
  - 4 cycles later `br_timer` = 0059 and `bt_timer` = 0959.
- Borrow chain with TOTAL_INIT = 16'h1000, ROUND_INIT = 16'h1000: first tick gives 0959 on both red timers.
- ROUND_INIT = 16'h0002: two ticks → `rr_timer` = 0000, `timeout` = 1, `loser` = 0, `running` = 0.
  - Further ticks and `move_done` have no effect.
- `move_done` on the exact tick cycle: no decrement that second and the turn switches.
- `pause` mid-second:
  - Timers and prescaler hold for 100 cycles.
  - After `start`, the next tick arrives after the remaining count only.
- `rst` while in OVER: all outputs return to their reset values.
